ntt_row_sched: RTL and testbench
================================

NTT_ROW_SCHED -- requirements
Module: ntt_row_sched

Interface
REQ-001 Parameter N, default 64, transform size (rows = columns = N, power of two).
REQ-002 Parameter ROW_LAT, default 8, fixed pipeline latency of the row MAC unit in cycles.
REQ-003 Parameter DW, default 64, coefficient/result width; WW, default 8, twiddle width.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to run a full N-row transform; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of a running transform.
REQ-008 busy  out  1  high from the first FETCH cycle through the last WRITE cycle.
REQ-009 done  out  1  one-cycle pulse when all N results are written.
REQ-010 mem_rd_en  out  1  coefficient/twiddle memory read strobe.
REQ-011 mem_addr  out  2*log2(N)  read address = row*N + col.
REQ-012 mem_x  in  DW  coefficient read data, valid one cycle after mem_rd_en.
REQ-013 mem_w  in  WW  twiddle read data, valid one cycle after mem_rd_en.
REQ-014 mac_clr  out  1  clears the row MAC accumulator.
REQ-015 mac_vld, mac_a (DW), mac_w (WW)  out  registered operand stream to the row MAC unit.
REQ-016 mac_out  in  DW  row MAC result, valid ROW_LAT cycles after the last mac_vld and held until mac_clr.
REQ-017 res_we, res_addr (log2(N)), res_data (DW)  out  result memory write port.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
REQ-019 IDLE -> FETCH on start=1; row=0, col=0.
REQ-020 FETCH lasts exactly N cycles; mem_rd_en=1, mem_addr=row*N+col, col increments each cycle; mac_clr=1 only in the col=0 cycle.
REQ-021 A read issued in cycle t drives mac_a/mac_w=mem_x/mem_w and mac_vld=1 in cycle t+2 (one memory latency plus one register stage).
REQ-022 DRAIN lasts exactly ROW_LAT+2 cycles, counted by a down-counter loaded on FETCH exit.
REQ-023 WRITE lasts one cycle: res_we=1, res_addr=row, res_data=mac_out.
REQ-024 WRITE -> FETCH with row+1 when row<N-1; WRITE -> DONE when row=N-1.
REQ-025 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-026 Per-row period = N+ROW_LAT+3 cycles; defaults give 75 cycles per row and 4800 cycles from start to done.
REQ-027 start while not in IDLE is ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-028 abort=1 in FETCH/DRAIN/WRITE returns to IDLE next cycle; no res_we in the abort cycle or afterwards; no done pulse.
REQ-029 col and row counters wrap only through the state transitions above; mem_addr never exceeds N*N-1.
REQ-030 mac_vld, mem_rd_en, res_we and done are 0 in IDLE.

Reset
REQ-031 rst=0 forces IDLE immediately; all outputs 0, counters 0, operand registers 0.
REQ-032 Reset mid-transform discards progress; after release the block waits in IDLE for a new start.

Structure
REQ-033 Package ntt_pkg holds the FSM state enum, N/ROW_LAT/DW/WW defaults and the derived address widths.
REQ-034 No sub-module; the scheduler is one FSM plus counters and an operand register stage, driving the existing row MAC unit.

Verification
REQ-035 Defaults, start pulse, memory model x[r][c]=r*64+c, w=1, MAC model sums -> done at cycle 4800 after start, res_data[r]=sum over c of (r*64+c), 64 writes in order.
REQ-036 Address trace: row 3 FETCH -> mem_addr 192..255 contiguous, mac_clr high only with addr 192, mac_vld high exactly 64 cycles starting 2 cycles after addr 192.
REQ-037 abort in DRAIN of row 5 -> IDLE next cycle, no res_we for row 5, no done; subsequent start completes normally.
REQ-038 start repeated during busy -> no restart, done count 1, total 4800 cycles.
REQ-039 rst=0 for 1 cycle during row 10 WRITE -> all outputs 0 asynchronously, res_we suppressed, stays IDLE until start.
REQ-040 N=4, ROW_LAT=2 -> row period 9 cycles, done at cycle 36, res_addr 0..3.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT row scheduler: FSM encoding, default geometry and derived widths.
package ntt_pkg;

   localparam int N_DEF       = 64;
   localparam int ROW_LAT_DEF = 8;
   localparam int DW_DEF      = 64;
   localparam int WW_DEF      = 8;

   localparam int ROW_W_DEF  = $clog2(N_DEF);
   localparam int ADDR_W_DEF = 2 * ROW_W_DEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_t;

   // Down-counter width able to hold ROW_LAT+1, the drain load value.
   function automatic int drain_cnt_w(input int row_lat);
      return $clog2(row_lat + 2);
   endfunction

endpackage

// File: rtl/ntt_row_sched.sv
// Row scheduler for an N-point NTT: streams one row of coefficients/twiddles into the row MAC,
// waits out the MAC latency, then writes the row result; repeats for all N rows.
module ntt_row_sched
   import ntt_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int ROW_LAT = ROW_LAT_DEF,
   parameter int DW      = DW_DEF,
   parameter int WW      = WW_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_rd_en,
   output logic [2*$clog2(N)-1:0]   mem_addr,
   input  logic [DW-1:0]            mem_x,
   input  logic [WW-1:0]            mem_w,
   output logic                     mac_clr,
   output logic                     mac_vld,
   output logic [DW-1:0]            mac_a,
   output logic [WW-1:0]            mac_w,
   input  logic [DW-1:0]            mac_out,
   output logic                     res_we,
   output logic [$clog2(N)-1:0]     res_addr,
   output logic [DW-1:0]            res_data
);

   localparam int ROW_W = $clog2(N);
   localparam int CNT_W = drain_cnt_w(ROW_LAT);

   localparam logic [ROW_W-1:0] IDX_LAST = ROW_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROW_LAT + 1);

   state_t             state_reg, state_next;
   logic [ROW_W-1:0]   row_reg, row_next;
   logic [ROW_W-1:0]   col_reg, col_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;

   // Operand pipeline: rd_d1 marks the cycle the memory data is valid, vld the cycle after.
   logic               rd_d1_reg, rd_d1_next;
   logic               vld_reg, vld_next;
   logic [DW-1:0]      a_reg, a_next;
   logic [WW-1:0]      w_reg, w_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         row_reg   <= '0;
         col_reg   <= '0;
         cnt_reg   <= '0;
         rd_d1_reg <= 1'b0;
         vld_reg   <= 1'b0;
         a_reg     <= '0;
         w_reg     <= '0;
      end else begin
         state_reg <= state_next;
         row_reg   <= row_next;
         col_reg   <= col_next;
         cnt_reg   <= cnt_next;
         rd_d1_reg <= rd_d1_next;
         vld_reg   <= vld_next;
         a_reg     <= a_next;
         w_reg     <= w_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      cnt_next   = cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               state_next = ST_FETCH;
               row_next   = '0;
               col_next   = '0;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_next = ST_IDLE;
               row_next   = '0;
               col_next   = '0;
               cnt_next   = '0;
            end else begin
               col_next = col_reg + 1'b1;
               if (col_reg == IDX_LAST) begin
                  state_next = ST_DRAIN;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_next = ST_IDLE;
               row_next   = '0;
               col_next   = '0;
               cnt_next   = '0;
            end else if (cnt_reg == '0) begin
               state_next = ST_WRITE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_next = ST_IDLE;
               row_next   = '0;
               col_next   = '0;
               cnt_next   = '0;
            end else if (row_reg == IDX_LAST) begin
               state_next = ST_DONE;
               row_next   = '0;
            end else begin
               state_next = ST_FETCH;
               row_next   = row_reg + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Abort flushes in-flight operands so nothing reaches the MAC after returning to IDLE.
   always_comb begin
      rd_d1_next = (state_reg == ST_FETCH) && !abort;
      vld_next   = rd_d1_reg && !abort;
      a_next     = '0;
      w_next     = '0;
      if (rd_d1_reg && !abort) begin
         a_next = mem_x;
         w_next = mem_w;
      end
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mac_clr   = 1'b0;
      res_we    = 1'b0;
      res_addr  = '0;
      res_data  = '0;
      case (state_reg)
         ST_FETCH: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mac_clr   = (col_reg == '0);
         end
         ST_DRAIN: begin
            busy = 1'b1;
         end
         ST_WRITE: begin
            busy     = 1'b1;
            res_we   = !abort;
            res_addr = row_reg;
            res_data = mac_out;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign mem_addr = {row_reg, col_reg};
   assign mac_vld  = vld_reg;
   assign mac_a    = a_reg;
   assign mac_w    = w_reg;

endmodule

// File: tb/tb_ntt_row_sched.sv
// Directed bench for ntt_row_sched: a default-size instance (64x64, latency 8) and a small one (4x4, latency 2).
module tb_ntt_row_sched;

   localparam int NL = 64;
   localparam int LL = 8;
   localparam int NS = 4;
   localparam int LS = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- large instance ----------------
   logic        start_l = 1'b0, abort_l = 1'b0;
   logic        busy_l, done_l, rd_l, clr_l, vld_l, we_l;
   logic [11:0] addr_l;
   logic [63:0] x_l = '0, a_l, out_l, data_l;
   logic [7:0]  w_l = '0, mw_l;
   logic [5:0]  raddr_l;

   ntt_row_sched #(.N(NL), .ROW_LAT(LL), .DW(64), .WW(8)) dut_l (
      .clk(clk), .rst(rst), .start(start_l), .abort(abort_l),
      .busy(busy_l), .done(done_l), .mem_rd_en(rd_l), .mem_addr(addr_l),
      .mem_x(x_l), .mem_w(w_l), .mac_clr(clr_l), .mac_vld(vld_l),
      .mac_a(a_l), .mac_w(mw_l), .mac_out(out_l),
      .res_we(we_l), .res_addr(raddr_l), .res_data(data_l)
   );

   // Memory model x[r][c] = r*N+c (equal to the address), w = 1; registered read.
   always @(posedge clk) begin
      x_l <= rd_l ? 64'(addr_l) : 64'd0;
      w_l <= 8'd1;
   end

   // MAC model: result visible ROW_LAT cycles after the last valid operand.
   logic [63:0] acc_l = '0;
   logic [63:0] pipe_l [LL];
   always @(posedge clk) begin
      if (clr_l) acc_l <= '0;
      else if (vld_l) acc_l <= acc_l + a_l * {56'd0, mw_l};
      pipe_l[0] <= acc_l;
      for (int i = 1; i < LL; i++) pipe_l[i] <= pipe_l[i-1];
   end
   assign out_l = pipe_l[LL-2];

   // ---------------- small instance ----------------
   logic        start_s = 1'b0, abort_s = 1'b0;
   logic        busy_s, done_s, rd_s, clr_s, vld_s, we_s;
   logic [3:0]  addr_s;
   logic [63:0] x_s = '0, a_s, out_s, data_s;
   logic [7:0]  w_s = '0, mw_s;
   logic [1:0]  raddr_s;

   ntt_row_sched #(.N(NS), .ROW_LAT(LS), .DW(64), .WW(8)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
      .busy(busy_s), .done(done_s), .mem_rd_en(rd_s), .mem_addr(addr_s),
      .mem_x(x_s), .mem_w(w_s), .mac_clr(clr_s), .mac_vld(vld_s),
      .mac_a(a_s), .mac_w(mw_s), .mac_out(out_s),
      .res_we(we_s), .res_addr(raddr_s), .res_data(data_s)
   );

   always @(posedge clk) begin
      x_s <= rd_s ? 64'(addr_s) : 64'd0;
      w_s <= 8'd1;
   end

   logic [63:0] acc_s = '0;
   logic [63:0] pipe_s [LS];
   always @(posedge clk) begin
      if (clr_s) acc_s <= '0;
      else if (vld_s) acc_s <= acc_s + a_s * {56'd0, mw_s};
      pipe_s[0] <= acc_s;
      for (int i = 1; i < LS; i++) pipe_s[i] <= pipe_s[i-1];
   end
   assign out_s = pipe_s[LS-2];

   // ---------------- monitors (sample on falling edge) ----------------
   int          wr_addr_l [$];
   logic [63:0] wr_data_l [$];
   int          wr_addr_s [$];
   logic [63:0] wr_data_s [$];
   int done_cnt_l = 0, done_cyc_l = 0, busy_done_l = 0;
   int done_cnt_s = 0, done_cyc_s = 0;
   int t192 = -1, trace_err = 0, clr_cnt3 = 0, clr192 = 0, vld_in = 0, vld_out = 0;
   logic        prev_rd = 1'b0;
   logic [11:0] prev_addr = '0;

   always @(negedge clk) begin
      if (we_l) begin
         wr_addr_l.push_back(int'(raddr_l));
         wr_data_l.push_back(data_l);
      end
      if (done_l) begin
         done_cnt_l  <= done_cnt_l + 1;
         done_cyc_l  <= cyc;
         busy_done_l <= busy_done_l + int'(busy_l);
      end
      if (rd_l && addr_l == 12'd192) t192 <= cyc;
      if (rd_l && addr_l > 12'd192 && addr_l <= 12'd255 && !(prev_rd && prev_addr == addr_l - 12'd1))
         trace_err <= trace_err + 1;
      if (clr_l && addr_l >= 12'd192 && addr_l <= 12'd255) begin
         clr_cnt3 <= clr_cnt3 + 1;
         if (addr_l == 12'd192) clr192 <= clr192 + 1;
      end
      if (t192 >= 0 && vld_l && cyc >= t192 + 2 && cyc <= t192 + 65) vld_in <= vld_in + 1;
      if (t192 >= 0 && vld_l && (cyc == t192 + 1 || cyc == t192 + 66)) vld_out <= vld_out + 1;
      prev_rd   <= rd_l;
      prev_addr <= addr_l;
      if (we_s) begin
         wr_addr_s.push_back(int'(raddr_s));
         wr_data_s.push_back(data_s);
      end
      if (done_s) begin
         done_cnt_s <= done_cnt_s + 1;
         done_cyc_s <= cyc;
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Full transform on the large instance; optional extra start pulses while busy.
   task automatic run_full_l(input string tag, input bit noise);
      int dbase, wbase, sc, n;
      dbase = done_cnt_l;
      wbase = wr_addr_l.size();
      @(negedge clk); #1;
      start_l = 1'b1;
      @(posedge clk); #1;
      sc = cyc;
      start_l = 1'b0;
      check({tag, "_busy_after_start"}, longint'(busy_l), 1);
      n = 0;
      while (done_cnt_l == dbase && n < 6000) begin
         @(negedge clk); #1;
         start_l = noise && (n == 100 || n == 3000);
         n++;
      end
      start_l = 1'b0;
      check({tag, "_done_seen"}, longint'(done_cnt_l != dbase), 1);
      check({tag, "_done_cycle"}, longint'(done_cyc_l - sc), 4800);
      check({tag, "_busy_in_done"}, longint'(busy_done_l), 0);
      repeat (5) @(negedge clk);
      #1;
      check({tag, "_done_count"}, longint'(done_cnt_l - dbase), 1);
      check({tag, "_idle_after"}, longint'(busy_l), 0);
      check({tag, "_writes"}, longint'(wr_addr_l.size() - wbase), NL);
      for (int r = 0; r < NL && wbase + r < wr_addr_l.size(); r++) begin
         check($sformatf("%s_addr%0d", tag, r), longint'(wr_addr_l[wbase+r]), r);
         check($sformatf("%s_data%0d", tag, r), longint'(wr_data_l[wbase+r]), 4096 * r + 2016);
      end
      $display("txn %s: done %0d cycles after start, %0d writes", tag, done_cyc_l - sc,
               wr_addr_l.size() - wbase);
   endtask

   task automatic run_full_s(input string tag);
      int dbase, wbase, sc, n;
      dbase = done_cnt_s;
      wbase = wr_addr_s.size();
      @(negedge clk); #1;
      start_s = 1'b1;
      @(posedge clk); #1;
      sc = cyc;
      start_s = 1'b0;
      check({tag, "_busy_after_start"}, longint'(busy_s), 1);
      n = 0;
      while (done_cnt_s == dbase && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, longint'(done_cnt_s != dbase), 1);
      check({tag, "_done_cycle"}, longint'(done_cyc_s - sc), 36);
      check({tag, "_writes"}, longint'(wr_addr_s.size() - wbase), NS);
      for (int r = 0; r < NS && wbase + r < wr_addr_s.size(); r++) begin
         check($sformatf("%s_addr%0d", tag, r), longint'(wr_addr_s[wbase+r]), r);
         check($sformatf("%s_data%0d", tag, r), longint'(wr_data_s[wbase+r]), 16 * r + 6);
      end
      $display("txn %s: done %0d cycles after start, %0d writes", tag, done_cyc_s - sc,
               wr_addr_s.size() - wbase);
   endtask

   initial begin
      int dbase, wbase, n, tb3, cb3, c192b, vib, vob;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", longint'(busy_l), 0);
      check("rst_done", longint'(done_l), 0);
      check("rst_rd_en", longint'(rd_l), 0);
      check("rst_addr", longint'(addr_l), 0);
      check("rst_vld", longint'(vld_l), 0);
      check("rst_we", longint'(we_l), 0);
      check("rst_mac_a", longint'(a_l), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("idle_no_start", longint'(busy_l), 0);
      $display("txn reset: released");

      // Small geometry
      run_full_s("small");

      // Default geometry with spurious starts and row-3 address trace
      tb3 = trace_err; cb3 = clr_cnt3; c192b = clr192; vib = vld_in; vob = vld_out;
      run_full_l("large_restart", 1'b1);
      check("row3_contig", longint'(trace_err - tb3), 0);
      check("row3_clr_count", longint'(clr_cnt3 - cb3), 1);
      check("row3_clr_at_192", longint'(clr192 - c192b), 1);
      check("row3_vld_count", longint'(vld_in - vib), 64);
      check("row3_vld_outside", longint'(vld_out - vob), 0);

      // Abort in row 5 DRAIN
      dbase = done_cnt_l;
      wbase = wr_addr_l.size();
      @(negedge clk); #1;
      start_l = 1'b1;
      @(posedge clk); #1;
      start_l = 1'b0;
      n = 0;
      while (!(rd_l && addr_l == 12'd383) && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      check("abort_reach_row5", longint'(n < 1000), 1);
      @(negedge clk); #1;
      check("abort_in_drain", longint'(busy_l && !rd_l), 1);
      abort_l = 1'b1;
      @(negedge clk); #1;
      abort_l = 1'b0;
      check("abort_idle", longint'(busy_l), 0);
      check("abort_vld_flushed", longint'(vld_l), 0);
      repeat (200) @(negedge clk);
      #1;
      check("abort_writes", longint'(wr_addr_l.size() - wbase), 5);
      check("abort_no_done", longint'(done_cnt_l - dbase), 0);
      check("abort_stays_idle", longint'(busy_l), 0);
      $display("txn abort: %0d writes before abort", wr_addr_l.size() - wbase);
      run_full_l("large_after_abort", 1'b0);

      // Reset asserted during row 10 WRITE
      dbase = done_cnt_l;
      wbase = wr_addr_l.size();
      @(negedge clk); #1;
      start_l = 1'b1;
      @(posedge clk); #1;
      start_l = 1'b0;
      n = 0;
      while (!(rd_l && addr_l == 12'd703) && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      check("rst_reach_row10", longint'(n < 1000), 1);
      repeat (LL + 3) @(posedge clk);
      #1;
      check("rst_in_write", longint'(we_l && raddr_l == 6'd10), 1);
      rst = 1'b0;
      #1;
      check("arst_we", longint'(we_l), 0);
      check("arst_busy", longint'(busy_l), 0);
      check("arst_rd_en", longint'(rd_l), 0);
      check("arst_addr", longint'(addr_l), 0);
      check("arst_vld", longint'(vld_l), 0);
      check("arst_mac_a", longint'(a_l), 0);
      check("arst_data", longint'(data_l), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("rst_stays_idle", longint'(busy_l), 0);
      check("rst_writes", longint'(wr_addr_l.size() - wbase), 10);
      check("rst_no_done", longint'(done_cnt_l - dbase), 0);
      $display("txn reset_mid: %0d writes before reset", wr_addr_l.size() - wbase);

      run_full_s("small_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
